rv_mdu_iterative: RTL

//  Iterative RV32M multiply/divide unit. It sits directly downstream of the register file.
//  op_a/op_b take RD1/RD2 (rs1/rs2). result feeds the WD3 write-back mux.
//  The multicycle controller pulses start, then holds the EX state until done.
//  One shared 32-step shift/add-subtract datapath serves all 8 M-extension ops.

---
 rtl/rv_mdu_pkg.sv | 29 ++
 rtl/rv_mdu_iterative_if.sv | 21 ++
 rtl/rv_mdu_iterative.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and iteration count.
package rv_mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned ITER_CNT = 32;
  localparam int unsigned CNT_W    = $clog2(ITER_CNT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  // Two's-complement magnitude of v when neg is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rv_mdu_iterative_if.sv
// Request/response bundle between the multicycle controller and the MDU.
interface rv_mdu_iterative_if;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/rv_mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one 33-bit adder/subtractor and a 64-bit
// shift register serve all eight ops (shift-add multiply, restoring divide).
module rv_mdu_iterative
  import rv_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  rv_mdu_iterative_if.slave mdu
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      acc_q, acc_d;
  logic [XLEN-1:0]  mag_a_q, mag_a_d;
  logic [XLEN-1:0]  mag_b_q, mag_b_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;

  // Operand conditioning at the accepting edge.
  logic        sign_a, sign_b, neg_in, special_in;
  logic [31:0] abs_a, abs_b, special_val;

  always_comb begin
    sign_a = mdu.op_a[31] & ((mdu.funct3 == F3_MULH) || (mdu.funct3 == F3_MULHSU) ||
                             (mdu.funct3 == F3_DIV)  || (mdu.funct3 == F3_REM));
    sign_b = mdu.op_b[31] & ((mdu.funct3 == F3_MULH) || (mdu.funct3 == F3_DIV) ||
                             (mdu.funct3 == F3_REM));
    abs_a  = mag32(mdu.op_a, sign_a);
    abs_b  = mag32(mdu.op_b, sign_b);
    neg_in = (mdu.funct3 == F3_REM) ? sign_a : (sign_a ^ sign_b);

    special_in  = 1'b0;
    special_val = '0;
    if (mdu.funct3[2] && (mdu.op_b == 32'd0)) begin
      special_in  = 1'b1;
      special_val = mdu.funct3[1] ? mdu.op_a : 32'hFFFF_FFFF;
    end else if (((mdu.funct3 == F3_DIV) || (mdu.funct3 == F3_REM)) &&
                 (mdu.op_a == 32'h8000_0000) && (mdu.op_b == 32'hFFFF_FFFF)) begin
      special_in  = 1'b1;
      special_val = mdu.funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Shared iteration datapath. Multiply: acc = {partial hi, multiplier shifting out}.
  // Divide: acc = {partial remainder, dividend shifting out / quotient shifting in}.
  logic        is_div, q_bit;
  logic [32:0] rem_sh, add_lhs, add_rhs, sum;
  logic [31:0] rem_new;
  logic [63:0] step_val, fix_val;

  always_comb begin
    is_div  = op_q[2];
    rem_sh  = {acc_q[63:32], acc_q[31]};
    add_lhs = is_div ? rem_sh : {1'b0, acc_q[63:32]};
    if (is_div) begin
      add_rhs = ~{1'b0, mag_b_q};
    end else begin
      add_rhs = acc_q[0] ? {1'b0, mag_a_q} : 33'd0;
    end
    sum     = add_lhs + add_rhs + {32'd0, is_div};
    // Remainder never reaches 2^32, so bit 32 of the difference is a clean borrow.
    q_bit   = ~sum[32];
    rem_new = q_bit ? sum[31:0] : rem_sh[31:0];

    if (is_div) begin
      step_val = {rem_new, acc_q[30:0], q_bit};
    end else begin
      step_val = {sum, acc_q[31:1]};
    end

    fix_val = acc_q;
    if (neg_q) begin
      if (!is_div) begin
        fix_val = 64'd0 - acc_q;
      end else if (op_q[1]) begin
        fix_val = {32'd0 - acc_q[63:32], acc_q[31:0]};
      end else begin
        fix_val = {acc_q[63:32], 32'd0 - acc_q[31:0]};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;

    if (mdu.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mdu.start) begin
            op_d    = mdu.funct3;
            neg_d   = neg_in;
            mag_a_d = abs_a;
            mag_b_d = abs_b;
            count_d = '0;
            if (special_in) begin
              // Both halves carry the value so the common result select applies.
              acc_d   = {special_val, special_val};
              neg_d   = 1'b0;
              state_d = StDone;
            end else begin
              acc_d   = {32'd0, mdu.funct3[2] ? abs_a : abs_b};
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d   = step_val;
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(ITER_CNT - 1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          acc_d   = fix_val;
          state_d = StDone;
        end
        StDone: begin
          // High half for MULH*/REM*, low half for MUL/DIV*.
          if (op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00)) begin
            result_d = acc_q[63:32];
          end else begin
            result_d = acc_q[31:0];
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign mdu.busy   = (state_q != StIdle);
  assign mdu.done   = done_q;
  assign mdu.result = result_q;

endmodule
